// File: rtl/gray_counter_conv.sv
// gray_counter_conv
//
// Parametrised binary/Gray counter with a programmable terminal count plus an
// independent, registered Gray-to-binary decode channel.
//
// The counter runs modulo MAX_COUNT+1. It supports up/down counting and a
// clamped synchronous load, and it flags each wrap with a one-cycle pulse.
// bin_out and gray_out come from the same edge, so they never disagree.
//
// Parameters:
//   WIDTH      counter / code width in bits (2..16)
//   MAX_COUNT  terminal binary count (1..2**WIDTH-1); 9 gives a BCD digit
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   en             count enable
//   up             1 = count up, 0 = count down
//   load           synchronous load strobe (beats en)
//   load_bin       binary load value, clamped to MAX_COUNT
//   bin_out        registered binary count
//   gray_out       registered Gray code of bin_out
//   wrap           one-cycle pulse while the wrapped value is first shown
//   g2b_in         Gray value to decode
//   g2b_valid_in   qualifier for g2b_in
//   g2b_out        decoded binary, one cycle after g2b_in
//   g2b_valid_out  g2b_valid_in delayed one cycle
//   step_err       (only with GRAY_STEP_CHECK_EN) sticky flag, raised when a
//                  non-wrap count step changes gray_out in other than one bit
//
// Optional feature macro: GRAY_STEP_CHECK_EN
module gray_counter_conv #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    input  logic [WIDTH-1:0] g2b_in,
    input  logic             g2b_valid_in,
    output logic [WIDTH-1:0] g2b_out,
    output logic             g2b_valid_out
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] g2b_q, g2b_d;
    logic             g2b_valid_q;

    // Next count: load beats enable, which beats hold. Both wrap points are
    // explicit, so a non-power-of-two terminal count never runs past MAX_C.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = (load_bin > MAX_C) ? MAX_C : load_bin;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX_C) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    bin_d = bin_q + ONE_C;
                end
            end else begin
                if (bin_q == '0) begin
                    bin_d  = MAX_C;
                    wrap_d = 1'b1;
                end else begin
                    bin_d = bin_q - ONE_C;
                end
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Gray-to-binary: each output bit is the XOR of all input bits at and
    // above its position. This uses the prefix-XOR from the MSB down.
    always_comb begin
        g2b_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            g2b_d[i] = ^(g2b_in >> i);
        end
    end

    // The counter and the decode channel are updated on the same edge. The
    // Gray code is registered from the next binary value, so the two
    // outputs never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q       <= '0;
            gray_q      <= '0;
            wrap_q      <= 1'b0;
            g2b_q       <= '0;
            g2b_valid_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            wrap_q      <= wrap_d;
            g2b_q       <= g2b_d;
            g2b_valid_q <= g2b_valid_in;
        end
    end

    assign bin_out       = bin_q;
    assign gray_out      = gray_q;
    assign wrap          = wrap_q;
    assign g2b_out       = g2b_q;
    assign g2b_valid_out = g2b_valid_q;

`ifdef GRAY_STEP_CHECK_EN
    logic             step_err_q;
    logic [WIDTH-1:0] step_diff;
    logic             step_bad;

    // Only plain count steps are judged. Loads and wraps may legally change
    // several bits, so they are excluded.
    assign step_diff = gray_q ^ gray_d;
    assign step_bad  = en && !load && !wrap_d && !$onehot(step_diff);

    // Sticky until reset so that a single bad step cannot be missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_err_q <= 1'b0;
        end else if (step_bad) begin
            step_err_q <= 1'b1;
        end
    end

    assign step_err = step_err_q;
`endif

endmodule
